// File: rtl/led_fader_pkg.sv
// Shared defaults, level type and saturating step for the LED fader.
package led_fader_pkg;

    localparam int unsigned N_LEDS_DEF   = 10;
    localparam int unsigned PWM_BITS_DEF = 8;
    localparam int unsigned TICK_DIV_DEF = 50000;
    localparam int unsigned STEP_DEF     = 4;

    typedef logic [PWM_BITS_DEF-1:0] level_t;

    // Moves level one step toward max_level (up) or zero (down), clamping at either end.
    function automatic logic [31:0] sat_step(
        input logic [31:0] level,
        input logic [31:0] step,
        input logic [31:0] max_level,
        input logic        up
    );
        logic [32:0] sum;
        logic [31:0] result;
        sum    = {1'b0, level} + {1'b0, step};
        result = '0;
        if (up) begin
            result = (sum > {1'b0, max_level}) ? max_level : sum[31:0];
        end else if (level > step) begin
            result = level - step;
        end
        return result;
    endfunction

endpackage

// File: rtl/led_fade_channel.sv
// One LED channel: brightness level register, saturating fade step, PWM comparator.
module led_fade_channel
    import led_fader_pkg::*;
#(
    parameter int unsigned PWM_BITS = PWM_BITS_DEF,
    parameter int unsigned STEP     = STEP_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                tick,
    input  logic                target,
    input  logic                bypass,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic [PWM_BITS-1:0] level,
    output logic                led_out
);

    localparam int unsigned MAX = (1 << PWM_BITS) - 1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level   <= '0;
            led_out <= 1'b0;
        end else begin
            led_out <= bypass ? target : (level > pwm_cnt);
            if (tick) begin
                level <= PWM_BITS'(sat_step(32'(level), 32'(STEP), 32'(MAX), target));
            end
        end
    end

endmodule

// File: rtl/led_fader.sv
// LED fader top: fade tick divider, shared PWM counter, per-channel faders, busy and PWM sync.
module led_fader
    import led_fader_pkg::*;
#(
    parameter int unsigned N_LEDS   = N_LEDS_DEF,
    parameter int unsigned PWM_BITS = PWM_BITS_DEF,
    parameter int unsigned TICK_DIV = TICK_DIV_DEF,
    parameter int unsigned STEP     = STEP_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N_LEDS-1:0] led_target,
    input  logic              enable,
    input  logic              bypass,
    output logic [N_LEDS-1:0] led_out,
    output logic              busy,
    output logic              pwm_sync
);

    localparam int unsigned         TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0]       TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [PWM_BITS-1:0] PWM_LAST  = PWM_BITS'((1 << PWM_BITS) - 2);
    localparam logic [PWM_BITS-1:0] LEVEL_MAX = '1;

    logic [TW-1:0]       tick_cnt;
    logic                tick;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] level [N_LEDS];
    logic [N_LEDS-1:0]   level_diff;

    assign tick = enable && (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt <= '0;
            pwm_cnt  <= '0;
            pwm_sync <= 1'b0;
            busy     <= 1'b0;
        end else begin
            tick_cnt <= (!enable || tick) ? '0 : tick_cnt + 1'b1;
            // pwm_cnt never reaches all-ones, so a full level reads as constant on
            pwm_cnt  <= (pwm_cnt == PWM_LAST) ? '0 : pwm_cnt + 1'b1;
            pwm_sync <= (pwm_cnt == PWM_LAST);
            busy     <= |level_diff;
        end
    end

    always_comb begin
        level_diff = '0;
        for (int unsigned i = 0; i < N_LEDS; i++) begin
            level_diff[i] = (level[i] != (led_target[i] ? LEVEL_MAX : '0));
        end
    end

    for (genvar i = 0; i < N_LEDS; i++) begin : g_ch
        led_fade_channel #(
            .PWM_BITS(PWM_BITS),
            .STEP    (STEP)
        ) u_ch (
            .clk    (clk),
            .reset_n(reset_n),
            .tick   (tick),
            .target (led_target[i]),
            .bypass (bypass),
            .pwm_cnt(pwm_cnt),
            .level  (level[i]),
            .led_out(led_out[i])
        );
    end

endmodule

// File: tb/tb_led_fader.sv
// Bench for led_fader with TICK_DIV=4, STEP=64, PWM_BITS=8: vector table plus per-cycle scoreboard.
module tb_led_fader;
    import led_fader_pkg::*;

    logic       clk;
    logic       reset_n;
    logic [9:0] led_target;
    logic       enable;
    logic       bypass;
    logic [9:0] led_out;
    logic       busy;
    logic       pwm_sync;

    int unsigned checks;
    int unsigned errors;

    typedef struct {
        logic [9:0]  led;
        logic        busy;
        logic        sync;
    } exp_t;

    typedef struct {
        logic [9:0]  tgt;
        logic        en;
        logic        byp;
        int unsigned n;
        logic        exp_busy;
        logic        chk_led;
        logic [9:0]  exp_led;
    } vec_t;

    exp_t        sb[$];
    vec_t        vecs[17];
    int unsigned m_level[10];
    int unsigned m_tick;
    int unsigned m_pwm;

    led_fader #(
        .N_LEDS  (10),
        .PWM_BITS(8),
        .TICK_DIV(4),
        .STEP    (64)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .led_target(led_target),
        .enable    (enable),
        .bypass    (bypass),
        .led_out   (led_out),
        .busy      (busy),
        .pwm_sync  (pwm_sync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int unsigned got, input int unsigned exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        foreach (m_level[i]) m_level[i] = 0;
        m_tick = 0;
        m_pwm  = 0;
        sb.delete();
    endtask

    // Reference behaviour for one clock: expected outputs pushed, then compared after the edge.
    task automatic cycle();
        exp_t e;
        exp_t g;
        logic tk;
        e = '{led: '0, busy: 1'b0, sync: 1'b0};
        if (!reset_n) begin
            sb.push_back(e);
            foreach (m_level[i]) m_level[i] = 0;
            m_tick = 0;
            m_pwm  = 0;
        end else begin
            tk = enable && (m_tick == 3);
            for (int i = 0; i < 10; i++) begin
                e.led[i] = bypass ? led_target[i] : (m_level[i] > m_pwm);
                if (m_level[i] != (led_target[i] ? 255 : 0)) e.busy = 1'b1;
            end
            e.sync = (m_pwm == 254);
            sb.push_back(e);
            if (tk) begin
                for (int i = 0; i < 10; i++) begin
                    if (led_target[i]) m_level[i] = (m_level[i] + 64 > 255) ? 255 : m_level[i] + 64;
                    else               m_level[i] = (m_level[i] < 64) ? 0 : m_level[i] - 64;
                end
            end
            m_tick = (!enable || tk) ? 0 : m_tick + 1;
            m_pwm  = (m_pwm == 254) ? 0 : m_pwm + 1;
        end
        @(posedge clk);
        #1;
        g = '{led: led_out, busy: busy, sync: pwm_sync};
        e = sb.pop_front();
        checks++;
        if (g != e) begin
            errors++;
            $display("FAIL cycle at %0t: led_out=%h busy=%b pwm_sync=%b expected led_out=%h busy=%b pwm_sync=%b",
                     $time, g.led, g.busy, g.sync, e.led, e.busy, e.sync);
        end
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int v = lo; v <= hi; v++) begin
            led_target = vecs[v].tgt;
            enable     = vecs[v].en;
            bypass     = vecs[v].byp;
            for (int unsigned c = 0; c < vecs[v].n; c++) cycle();
            chk($sformatf("vec%0d busy", v), 32'(busy), 32'(vecs[v].exp_busy));
            if (vecs[v].chk_led) chk($sformatf("vec%0d led_out", v), 32'(led_out), 32'(vecs[v].exp_led));
        end
    endtask

    // Waits for pwm_sync, then counts led_out[0] high cycles over one 255-cycle PWM period.
    task automatic measure_duty(input string name, input int unsigned exp_high);
        int unsigned waited;
        int unsigned high;
        int          first;
        waited = 0;
        while (!pwm_sync && waited < 300) begin
            cycle();
            waited++;
        end
        if (!pwm_sync) begin
            chk({name, " sync timeout"}, 0, 1);
        end else begin
            high  = 0;
            first = -1;
            for (int k = 0; k < 255; k++) begin
                if (k > 0) cycle();
                if (led_out[0]) begin
                    high++;
                    if (first < 0) first = k;
                end
            end
            chk({name, " high cycles"}, high, exp_high);
            chk({name, " first high offset"}, 32'(first), 1);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        //          tgt      en    byp   n    busy  chk   led
        vecs[0]  = '{10'h001, 1'b1, 1'b0, 16,  1'b1, 1'b0, 10'h000};
        vecs[1]  = '{10'h001, 1'b1, 1'b0, 1,   1'b0, 1'b1, 10'h001};
        vecs[2]  = '{10'h001, 1'b1, 1'b0, 300, 1'b0, 1'b1, 10'h001};
        vecs[3]  = '{10'h001, 1'b1, 1'b0, 8,   1'b1, 1'b0, 10'h000};
        vecs[4]  = '{10'h000, 1'b1, 1'b0, 8,   1'b1, 1'b0, 10'h000};
        vecs[5]  = '{10'h000, 1'b1, 1'b0, 1,   1'b0, 1'b1, 10'h000};
        vecs[6]  = '{10'h000, 1'b1, 1'b0, 20,  1'b0, 1'b1, 10'h000};
        vecs[7]  = '{10'h001, 1'b0, 1'b0, 1,   1'b1, 1'b0, 10'h000};
        vecs[8]  = '{10'h001, 1'b1, 1'b0, 4,   1'b1, 1'b0, 10'h000};
        vecs[9]  = '{10'h001, 1'b1, 1'b0, 8,   1'b1, 1'b0, 10'h000};
        vecs[10] = '{10'h001, 1'b0, 1'b0, 100, 1'b1, 1'b0, 10'h000};
        vecs[11] = '{10'h001, 1'b1, 1'b0, 4,   1'b1, 1'b0, 10'h000};
        vecs[12] = '{10'h001, 1'b1, 1'b0, 1,   1'b0, 1'b1, 10'h001};
        vecs[13] = '{10'h2AA, 1'b1, 1'b1, 1,   1'b1, 1'b1, 10'h2AA};
        vecs[14] = '{10'h2AA, 1'b1, 1'b1, 30,  1'b0, 1'b1, 10'h2AA};
        vecs[15] = '{10'h2AA, 1'b1, 1'b0, 1,   1'b0, 1'b1, 10'h2AA};
        vecs[16] = '{10'h2AA, 1'b1, 1'b0, 10,  1'b0, 1'b1, 10'h2AA};

        reset_n    = 1'b0;
        led_target = '0;
        enable     = 1'b0;
        bypass     = 1'b0;
        model_clear();
        #3;
        chk("reset led_out", 32'(led_out), 0);
        chk("reset busy", 32'(busy), 0);
        chk("reset pwm_sync", 32'(pwm_sync), 0);
        cycle();
        cycle();
        reset_n = 1'b1;
        cycle();

        // Fade in to full, then constant on.
        run_vecs(0, 2);

        // Asynchronous reset mid-run: outputs clear before any clock edge.
        reset_n = 1'b0;
        #1;
        chk("midrun reset led_out", 32'(led_out), 0);
        chk("midrun reset busy", 32'(busy), 0);
        chk("midrun reset pwm_sync", 32'(pwm_sync), 0);
        model_clear();
        enable     = 1'b0;
        led_target = '0;
        cycle();
        cycle();
        reset_n = 1'b1;
        cycle();
        cycle();

        // Reversal at 128: 64 then 0, no wrap.
        run_vecs(3, 6);

        // Duty at level 64 with fading frozen.
        run_vecs(7, 8);
        enable = 1'b0;
        measure_duty("duty64", 64);

        // Freeze at 192, hold, re-enable: step exactly 4 cycles later.
        run_vecs(9, 10);
        measure_duty("duty192", 192);
        run_vecs(11, 12);

        // Bypass with fading continuing underneath.
        run_vecs(13, 16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
